// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI frame master.
package spi_pkg;

    localparam int unsigned SPI_DATA_W  = 12;
    localparam int unsigned SPI_CLK_DIV = 4;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StShift,
        StHold
    } spi_state_t;

endpackage

// File: rtl/spi_sclk_div.sv
// Free-running phase divider: one-cycle tick every CLK_DIV clocks while run is high.
module spi_sclk_div
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count up to LAST then restart; held at zero while stopped.
    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Divider counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 master: one DATA_W-bit full-duplex frame per start, MSB first.
module spi_frame_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = SPI_CLK_DIV,
    parameter int unsigned DATA_W  = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              abort,
    input  logic              clr,
    output logic              busy,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              cnt_en,
    output logic              cnt_clr
);

    localparam int unsigned BW = $clog2(DATA_W + 1);
    // The first rising edge is issued from SETUP, so SHIFT sees DATA_W-1 more.
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    spi_state_t state_q, state_d;

    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              rx_valid_q, rx_valid_d;
    logic              cnt_clr_q;
    logic              tick;
    logic              kill;

    // Ticks land exactly on state transitions, so the divider restarts with each state.
    spi_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .clk  (clk),
        .rst  (rst),
        .run  (state_q != StIdle),
        .tick (tick)
    );

    assign kill = abort && (state_q != StIdle);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (start) state_d = StSetup;
                StSetup: if (tick) state_d = StShift;
                StShift: if (tick && sclk_q && (bit_cnt_q == LAST_BIT)) state_d = StHold;
                StHold:  if (tick) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Datapath and output next values.
    always_comb begin
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        bit_cnt_d  = bit_cnt_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        if (kill) begin
            cs_n_d    = 1'b1;
            sclk_d    = 1'b0;
            mosi_d    = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        tx_sr_d   = tx_data;
                        cs_n_d    = 1'b0;
                        busy_d    = 1'b1;
                        mosi_d    = tx_data[DATA_W-1];
                        bit_cnt_d = '0;
                    end
                end
                StSetup: begin
                    if (tick) begin
                        sclk_d    = 1'b1;
                        rx_sr_d   = {rx_sr_q[DATA_W-2:0], miso};
                        bit_cnt_d = '0;
                    end
                end
                StShift: begin
                    if (tick) begin
                        if (sclk_q) begin
                            sclk_d = 1'b0;
                            if (bit_cnt_q == LAST_BIT) begin
                                // Final falling edge leaves mosi on the last bit.
                                bit_cnt_d = '0;
                            end else begin
                                tx_sr_d = tx_sr_q << 1;
                                mosi_d  = tx_sr_q[DATA_W-2];
                            end
                        end else begin
                            sclk_d    = 1'b1;
                            rx_sr_d   = {rx_sr_q[DATA_W-2:0], miso};
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (tick) begin
                        cs_n_d     = 1'b1;
                        mosi_d     = 1'b0;
                        busy_d     = 1'b0;
                        rx_data_d  = rx_sr_q;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            bit_cnt_q  <= bit_cnt_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // Downstream counter clear, delayed one clock and independent of the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_clr_q <= 1'b0;
        end else begin
            cnt_clr_q <= clr;
        end
    end

    assign busy     = busy_q;
    assign sclk     = sclk_q;
    assign cs_n     = cs_n_q;
    assign mosi     = mosi_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign cnt_en   = rx_valid_q;
    assign cnt_clr  = cnt_clr_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master with a slave model and a downstream counter model.
module tb_spi_frame_master;
    import spi_pkg::*;

    localparam int unsigned DW = SPI_DATA_W;
    localparam int unsigned CD = SPI_CLK_DIV;
    localparam int FRAME_LEN = (2 * DW + 1) * CD;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] tx_data;
    logic          abort;
    logic          clr;
    logic          busy;
    logic          sclk;
    logic          cs_n;
    logic          mosi;
    logic          miso;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          cnt_en;
    logic          cnt_clr;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    spi_frame_master #(
        .CLK_DIV (CD),
        .DATA_W  (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .tx_data  (tx_data),
        .abort    (abort),
        .clr      (clr),
        .busy     (busy),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr)
    );

    // Slave: loopback, or shifts slave_word out MSB first, updating after each sclk fall.
    logic          loopback = 1'b1;
    logic [DW-1:0] slave_word = '0;
    logic [DW-1:0] slave_sr = '0;
    logic          slave_bit = 1'b0;
    logic          prev_cs_n = 1'b1;
    logic          prev_sclk = 1'b0;

    assign miso = loopback ? mosi : slave_bit;

    always @(negedge clk) begin
        if (prev_cs_n && !cs_n) begin
            slave_bit <= slave_word[DW-1];
            slave_sr  <= slave_word << 1;
        end else if (!cs_n && prev_sclk && !sclk) begin
            slave_bit <= slave_sr[DW-1];
            slave_sr  <= slave_sr << 1;
        end
        prev_cs_n <= cs_n;
        prev_sclk <= sclk;
    end

    // Downstream 12-bit frame counter: rst2 (cnt_clr) dominates enable.
    logic [11:0] frame_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) frame_cnt <= '0;
        else if (cnt_clr) frame_cnt <= '0;
        else if (cnt_en) frame_cnt <= frame_cnt + 12'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Runs one frame from the current negedge; returns at the negedge after completion.
    task automatic do_frame(input logic [DW-1:0] tx, input logic [DW-1:0] exp_rx,
                            input bit timing, input bit poke_start, input bit clr_done,
                            input string tag);
        int rises = 0;
        int bad_phase = 0;
        int cs_low = 0;
        int last_edge = 0;
        int valid_at = -1;
        logic prev_s = 1'b0;
        logic mosi_one;
        tx_data = tx;
        start = 1'b1;
        exp_q.push_back(exp_rx);
        @(negedge clk);
        start = 1'b0;
        tx_data = '1;
        check({tag, "_cs_fall"}, cs_n, 0);
        check({tag, "_busy_rise"}, busy, 1);
        cs_low = 1;
        mosi_one = mosi;
        for (int c = 1; c <= FRAME_LEN + 20 && valid_at < 0; c++) begin
            if (poke_start && (c == 10 || c == FRAME_LEN)) start = 1'b1;
            if (clr_done && c == FRAME_LEN) clr = 1'b1;
            @(negedge clk);
            start = 1'b0;
            clr = 1'b0;
            if (sclk !== prev_s) begin
                if (sclk) rises++;
                if (c - last_edge != CD) bad_phase++;
                last_edge = c;
                prev_s = sclk;
            end
            if (!cs_n) cs_low++;
            if (mosi) mosi_one = 1'b1;
            if (rx_valid) begin
                valid_at = c;
                check({tag, "_cnt_en"}, cnt_en, 1);
                check({tag, "_cs_rise"}, cs_n, 1);
                check({tag, "_busy_fall"}, busy, 0);
                if (clr_done) check({tag, "_cnt_clr"}, cnt_clr, 1);
                if (exp_q.size() > 0) check({tag, "_rx_data"}, rx_data, exp_q.pop_front());
                else check({tag, "_unexpected_valid"}, rx_valid, 0);
            end
        end
        check({tag, "_valid_at"}, valid_at, FRAME_LEN);
        if (timing) begin
            check({tag, "_rises"}, rises, DW);
            check({tag, "_bad_phase"}, bad_phase, 0);
            check({tag, "_cs_low"}, cs_low, FRAME_LEN);
        end
        if (tx == '0) check({tag, "_mosi_zero"}, mosi_one, 0);
        if (poke_start) begin
            @(negedge clk);
            check({tag, "_late_start_ignored"}, cs_n, 1);
            check({tag, "_idle_busy"}, busy, 0);
            check({tag, "_valid_pulse"}, rx_valid, 0);
        end
    endtask

    // Aborts a frame at edge E+abort_at, with start asserted on the same edge.
    task automatic do_abort(input logic [DW-1:0] tx, input int abort_at,
                            input logic [DW-1:0] keep_rx);
        int pulses = 0;
        int cs_low = 0;
        tx_data = tx;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < abort_at; c++) @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_cs_n", cs_n, 1);
        check("abort_sclk", sclk, 0);
        check("abort_busy", busy, 0);
        check("abort_mosi", mosi, 0);
        for (int c = 0; c < FRAME_LEN + 20; c++) begin
            @(negedge clk);
            if (rx_valid || cnt_en) pulses++;
            if (!cs_n) cs_low++;
        end
        check("abort_no_pulse", pulses, 0);
        check("abort_start_ignored", cs_low, 0);
        check("abort_rx_kept", rx_data, keep_rx);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int active;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        clr = 1'b0;
        tx_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_cs_n", cs_n, 1);
        check("rst_busy", busy, 0);
        check("rst_rx_data", rx_data, 0);

        // Idle for 50 cycles with no start.
        pulses = 0;
        active = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (rx_valid || cnt_en || cnt_clr) pulses++;
            if (!cs_n || sclk || busy) active++;
        end
        check("idle_pulses", pulses, 0);
        check("idle_active", active, 0);

        // Loopback frame with full timing checks.
        loopback = 1'b1;
        do_frame(12'hA5C, 12'hA5C, 1'b1, 1'b0, 1'b0, "loop_a5c");
        @(negedge clk);
        check("cnt_after_first", frame_cnt, 1);

        // Asynchronous reset in the middle of a frame, between clock edges.
        tx_data = 12'hFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_cs_n", cs_n, 1);
        check("midrst_sclk", sclk, 0);
        check("midrst_mosi", mosi, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rx_data", rx_data, 0);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_cnt_en", cnt_en, 0);
        check("midrst_cnt_clr", cnt_clr, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Slave returns a fixed word while master sends zero.
        loopback = 1'b0;
        slave_word = 12'h3F1;
        do_frame(12'h000, 12'h3F1, 1'b1, 1'b0, 1'b0, "slave_3f1");
        loopback = 1'b1;

        // Start at E+10 and on the completion edge must be ignored.
        do_frame(12'h6B3, 12'h6B3, 1'b0, 1'b1, 1'b0, "poke");

        // Back-to-back: second start lands one cycle after busy falls.
        do_frame(12'h35A, 12'h35A, 1'b0, 1'b0, 1'b0, "b2b_first");
        do_frame(12'h0F0, 12'h0F0, 1'b1, 1'b0, 1'b0, "b2b_second");

        // Abort mid-frame, then a normal frame.
        do_abort(12'h999, 37, 12'h0F0);
        do_frame(12'h001, 12'h001, 1'b0, 1'b0, 1'b0, "after_abort");

        // Counter clear coinciding with cnt_en drops that frame.
        do_frame(12'h7E7, 12'h7E7, 1'b0, 1'b0, 1'b1, "clr_done");
        @(negedge clk);
        check("cnt_after_clr", frame_cnt, 0);
        do_frame(12'h111, 12'h111, 1'b0, 1'b0, 1'b0, "cnt_1");
        do_frame(12'h222, 12'h222, 1'b0, 1'b0, 1'b0, "cnt_2");
        do_frame(12'h333, 12'h333, 1'b0, 1'b0, 1'b0, "cnt_3");
        @(negedge clk);
        check("cnt_after_three", frame_cnt, 3);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
